sram_bus_bridge: RTL and testbench
==================================

SRAM_BUS_BRIDGE -- requirements
Module: sram_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1, meaning a data access is issued before an instruction fetch captured in the same cycle (0 = fetch first).
REQ-002 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port inst_sram_en  in  1  fetch request from core.
REQ-005 SHALL have port inst_sram_addr  in  32  fetch address.
REQ-006 SHALL have port inst_sram_rdata  out  32  fetched instruction to core.
REQ-007 SHALL have port data_sram_en  in  1  data request from core.
REQ-008 SHALL have port data_sram_wen  in  4  byte write strobes; 0 means read.
REQ-009 SHALL have port data_sram_addr  in  32  data address.
REQ-010 SHALL have port data_sram_wdata  in  32  store data.
REQ-011 SHALL have port data_sram_rdata  out  32  load data to core.
REQ-012 SHALL have port stallreq  out  1  freeze request to core pipeline.
REQ-013 SHALL have port bus_req  out  1  shared-bus request valid.
REQ-014 SHALL have port bus_wr  out  1  1 = write.
REQ-015 SHALL have port bus_wstrb  out  4  byte strobes, valid when bus_wr=1.
REQ-016 SHALL have port bus_addr  out  32  bus address.
REQ-017 SHALL have port bus_wdata  out  32  bus write data.
REQ-018 SHALL have port bus_addr_ok  in  1  request accepted this cycle.
REQ-019 SHALL have port bus_data_ok  in  1  response (read data or write ack) this cycle.
REQ-020 SHALL have port bus_rdata  in  32  read data, valid with bus_data_ok.

Function
REQ-021 SHALL use states IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
REQ-022 IDLE: SHALL capture every asserted request (addr, wen, wdata) into holding registers at the cycle edge; none asserted -> stay IDLE.
REQ-023 IDLE with any capture SHALL go to the first pending access in DATA_FIRST order (D_REQ or I_REQ).
REQ-024 stallreq SHALL be a combinational 1 whenever state is neither IDLE nor DONE, and SHALL be 1 in IDLE during a cycle with any request asserted.
REQ-025 D_REQ/I_REQ: bus_req=1 with the held fields; bus_wr=(held wen!=0) for data, 0 for fetch; bus_wstrb=held wen; bus_addr/bus_wdata SHALL stay stable until bus_addr_ok.
REQ-026 bus_addr_ok in *_REQ SHALL move to the matching *_WAIT; bus_req SHALL be 0 in every other state.
REQ-027 *_WAIT: bus_data_ok SHALL latch bus_rdata into the matching rdata register (reads only; writes leave data_sram_rdata unchanged) then go to the other pending access, or DONE if none.
REQ-028 bus_data_ok while not in *_WAIT SHALL be ignored.
REQ-029 DONE: stallreq=0 for exactly one cycle, then IDLE; holding-valid flags SHALL clear.
REQ-030 inst_sram_rdata/data_sram_rdata SHALL be registered and hold their last value until overwritten by REQ-027.
REQ-031 Each access SHALL take at least 2 cycles (REQ + WAIT); zero-wait bus: single access 3 cycles IDLE->DONE, two accesses 5.
REQ-032 bus_addr_ok and bus_data_ok high together in *_REQ SHALL be treated as accept only; data is taken at the next bus_data_ok in *_WAIT.
REQ-033 Only one bus transaction SHALL be outstanding at any time.

Reset
REQ-034 aresetn=0 at a rising edge SHALL force IDLE, clear holding-valid flags, and drive bus_req=0 and both rdata outputs to 32'h0; stallreq follows REQ-024.
REQ-035 Reset mid-transaction SHALL abandon it without any further bus_req; a later bus_data_ok SHALL be ignored.

Verification
REQ-036 Fetch only, addr 0xBFC00000, bus returns 0x3C08BFAF one cycle after accept -> one read at 0xBFC00000, inst_sram_rdata=0x3C08BFAF, stallreq high 3 cycles.
REQ-037 Fetch + store (wen=4'b0011, addr 0x80000010, wdata 0x1234ABCD) same cycle, DATA_FIRST=1 -> write issued first with wstrb 0011, then fetch; stallreq 5 cycles on zero-wait bus.
REQ-038 Load 0x80000020, bus_addr_ok delayed 4 cycles -> address fields stable throughout; data_sram_rdata updates only on bus_data_ok.
REQ-039 Spurious bus_data_ok in IDLE with rdata 0xDEADBEEF -> both rdata outputs unchanged.
REQ-040 aresetn low in D_WAIT -> IDLE next cycle, rdata 0, no bus_req until a new core request.

Source files
------------

// File: rtl/sram_bus_bridge.sv
// Bridges the core's split instruction/data SRAM ports onto one shared request/response bus.
// Requests seen in IDLE are captured and serialised, with the core stalled until DONE.
module sram_bus_bridge #(
   parameter int DATA_FIRST = 1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      D_REQ,
      D_WAIT,
      I_REQ,
      I_WAIT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        i_pend;
   logic        d_pend;
   logic [31:0] i_addr_q;
   logic [31:0] d_addr_q;
   logic [31:0] d_wdata_q;
   logic [3:0]  d_wen_q;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;
   logic        any_req;

   assign any_req         = inst_sram_en | data_sram_en;
   assign inst_sram_rdata = i_rdata_q;
   assign data_sram_rdata = d_rdata_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stallreq  = 1'b1;
      bus_req   = 1'b0;
      bus_wr    = 1'b0;
      bus_wstrb = '0;
      bus_addr  = d_addr_q;
      bus_wdata = d_wdata_q;
      unique case (state)
         IDLE: begin
            stallreq = any_req;
            if (any_req) begin
               if (DATA_FIRST != 0) state_nxt = data_sram_en ? D_REQ : I_REQ;
               else                 state_nxt = inst_sram_en ? I_REQ : D_REQ;
            end
         end
         D_REQ: begin
            bus_req   = 1'b1;
            bus_wr    = |d_wen_q;
            bus_wstrb = d_wen_q;
            if (bus_addr_ok) state_nxt = D_WAIT;
         end
         D_WAIT: begin
            if (bus_data_ok) state_nxt = i_pend ? I_REQ : DONE;
         end
         I_REQ: begin
            bus_req  = 1'b1;
            bus_addr = i_addr_q;
            if (bus_addr_ok) state_nxt = I_WAIT;
         end
         I_WAIT: begin
            bus_addr = i_addr_q;
            if (bus_data_ok) state_nxt = d_pend ? D_REQ : DONE;
         end
         DONE: begin
            stallreq  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending flags drop as each access completes so the WAIT states can pick the remaining one.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         i_pend    <= 1'b0;
         d_pend    <= 1'b0;
         i_addr_q  <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_wen_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (inst_sram_en) begin
                  i_pend   <= 1'b1;
                  i_addr_q <= inst_sram_addr;
               end
               if (data_sram_en) begin
                  d_pend    <= 1'b1;
                  d_addr_q  <= data_sram_addr;
                  d_wen_q   <= data_sram_wen;
                  d_wdata_q <= data_sram_wdata;
               end
            end
            D_WAIT: begin
               if (bus_data_ok) begin
                  d_pend <= 1'b0;
                  if (d_wen_q == 4'b0000) d_rdata_q <= bus_rdata;
               end
            end
            I_WAIT: begin
               if (bus_data_ok) begin
                  i_pend    <= 1'b0;
                  i_rdata_q <= bus_rdata;
               end
            end
            DONE: begin
               i_pend <= 1'b0;
               d_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Self-checking bench for sram_bus_bridge: a table of core requests played against a
// bus slave model, with a scoreboard of expected bus transactions in issue order.
module tb_sram_bus_bridge;

   logic        aclk;
   logic        aresetn;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   sram_bus_bridge #(.DATA_FIRST(1)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .stallreq        (stallreq),
      .bus_req         (bus_req),
      .bus_wr          (bus_wr),
      .bus_wstrb       (bus_wstrb),
      .bus_addr        (bus_addr),
      .bus_wdata       (bus_wdata),
      .bus_addr_ok     (bus_addr_ok),
      .bus_data_ok     (bus_data_ok),
      .bus_rdata       (bus_rdata)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct {
      logic        is_data;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      logic        i_en;
      logic [31:0] i_addr;
      logic        d_en;
      logic [3:0]  wen;
      logic [31:0] d_addr;
      logic [31:0] wdata;
      int unsigned delay;
      logic        combo;
      int unsigned exp_stall;
   } vec_t;

   txn_t        sb[$];
   vec_t        vecs[6];
   int          checks;
   int          errors;
   logic [31:0] exp_i_rdata;
   logic [31:0] exp_d_rdata;
   int unsigned cur_delay;
   int unsigned wait_cnt;
   logic        cur_combo;
   logic        acc_flag;
   logic        spur;
   logic [31:0] acc_rdata;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave model: addr_ok after cur_delay cycles of bus_req, data_ok the cycle after accept.
   task automatic slave_step();
      txn_t t;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      if (spur) begin
         bus_data_ok = 1'b1;
         bus_rdata   = 32'hDEAD_BEEF;
         spur        = 1'b0;
      end else if (acc_flag) begin
         chk("req_in_wait", 32'(bus_req), 32'd0);
         bus_data_ok = 1'b1;
         bus_rdata   = acc_rdata;
         acc_flag    = 1'b0;
      end else if (sb.size() == 0) begin
         chk("no_req", 32'(bus_req), 32'd0);
         if (bus_req) begin
            bus_addr_ok = 1'b1;
            acc_flag    = 1'b1;
            acc_rdata   = '0;
         end
      end else if (bus_req) begin
         t = sb[0];
         if (wait_cnt < cur_delay) begin
            wait_cnt++;
            chk("hold_addr", bus_addr, t.addr);
            chk("hold_wr", 32'(bus_wr), 32'(t.wr));
            if (t.wr) chk("hold_wdata", bus_wdata, t.wdata);
            if (t.is_data) chk("rdata_d_early", data_sram_rdata, exp_d_rdata);
            else           chk("rdata_i_early", inst_sram_rdata, exp_i_rdata);
         end else begin
            wait_cnt    = 0;
            t           = sb.pop_front();
            bus_addr_ok = 1'b1;
            chk("bus_addr", bus_addr, t.addr);
            chk("bus_wr", 32'(bus_wr), 32'(t.wr));
            if (t.is_data) chk("bus_wstrb", 32'(bus_wstrb), 32'(t.wstrb));
            if (t.wr) chk("bus_wdata", bus_wdata, t.wdata);
            acc_flag  = 1'b1;
            acc_rdata = t.wr ? 32'hBAD0_BAD0 : mem_rd(t.addr);
            if (cur_combo) begin
               bus_data_ok = 1'b1;
               bus_rdata   = 32'h0BAD_0BAD;
            end
         end
      end
   endtask

   task automatic cycle(output logic s);
      #1;
      s = stallreq;
      slave_step();
      @(negedge aclk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      txn_t        t;
      logic        s;
      int unsigned n;
      int unsigned guard;
      n               = 0;
      guard           = 0;
      inst_sram_en    = v.i_en;
      inst_sram_addr  = v.i_addr;
      data_sram_en    = v.d_en;
      data_sram_wen   = v.wen;
      data_sram_addr  = v.d_addr;
      data_sram_wdata = v.wdata;
      cur_delay       = v.delay;
      cur_combo       = v.combo;
      wait_cnt        = 0;
      if (v.d_en) begin
         t.is_data = 1'b1;
         t.wr      = (v.wen != 4'b0000);
         t.wstrb   = v.wen;
         t.addr    = v.d_addr;
         t.wdata   = v.wdata;
         sb.push_back(t);
      end
      if (v.i_en) begin
         t.is_data = 1'b0;
         t.wr      = 1'b0;
         t.wstrb   = 4'b0000;
         t.addr    = v.i_addr;
         t.wdata   = '0;
         sb.push_back(t);
      end
      do begin
         cycle(s);
         if (s === 1'b1) n++;
         guard++;
      end while (s === 1'b1 && guard < 60);
      chk($sformatf("v%0d_done_reached", idx), 32'(s), 32'd0);
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      if (v.i_en) exp_i_rdata = mem_rd(v.i_addr);
      if (v.d_en && v.wen == 4'b0000) exp_d_rdata = mem_rd(v.d_addr);
      chk($sformatf("v%0d_stall_cycles", idx), n, v.exp_stall);
      chk($sformatf("v%0d_inst_rdata", idx), inst_sram_rdata, exp_i_rdata);
      chk($sformatf("v%0d_data_rdata", idx), data_sram_rdata, exp_d_rdata);
      chk($sformatf("v%0d_sb_drained", idx), 32'(sb.size()), 32'd0);
      sb.delete();
      acc_flag  = 1'b0;
      cur_combo = 1'b0;
   endtask

   initial begin
      logic s;
      checks          = 0;
      errors          = 0;
      aresetn         = 1'b0;
      inst_sram_en    = 1'b0;
      inst_sram_addr  = '0;
      data_sram_en    = 1'b0;
      data_sram_wen   = '0;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      bus_addr_ok     = 1'b0;
      bus_data_ok     = 1'b0;
      bus_rdata       = '0;
      exp_i_rdata     = '0;
      exp_d_rdata     = '0;
      cur_delay       = 0;
      cur_combo       = 1'b0;
      wait_cnt        = 0;
      acc_flag        = 1'b0;
      spur            = 1'b0;
      acc_rdata       = '0;

      //           i_en  i_addr         d_en  wen      d_addr         wdata          dly combo stall
      vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 3};
      vecs[1] = '{1'b1, 32'hBFC0_0000, 1'b1, 4'b0011, 32'h8000_0010, 32'h1234_ABCD, 0, 1'b0, 5};
      vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 4'b0000, 32'h8000_0020, 32'h0000_0000, 4, 1'b0, 7};
      vecs[3] = '{1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_0024, 32'h0000_0000, 0, 1'b1, 5};
      vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 4'b1111, 32'h8000_0030, 32'hCAFE_F00D, 1, 1'b0, 4};
      vecs[5] = '{1'b1, 32'hBFC0_0008, 1'b1, 4'b0000, 32'h8000_0028, 32'h0000_0000, 2, 1'b0, 9};

      repeat (2) @(negedge aclk);
      #1;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
      chk("rst_data_rdata", data_sram_rdata, 32'd0);
      chk("rst_stallreq", 32'(stallreq), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      cycle(s);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Stray data_ok while idle must not disturb either read register.
      spur = 1'b1;
      cycle(s);
      chk("spur_stall", 32'(s), 32'd0);
      cycle(s);
      chk("spur_inst_rdata", inst_sram_rdata, exp_i_rdata);
      chk("spur_data_rdata", data_sram_rdata, exp_d_rdata);

      // Reset while D_WAIT: the pending response is dropped and outputs clear.
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'b0000;
      data_sram_addr = 32'h8000_0040;
      cur_delay      = 0;
      wait_cnt       = 0;
      sb.push_back('{1'b1, 1'b0, 4'b0000, 32'h8000_0040, 32'h0000_0000});
      cycle(s);
      cycle(s);
      #1;
      chk("wait_stall", 32'(stallreq), 32'd1);
      chk("wait_no_req", 32'(bus_req), 32'd0);
      @(negedge aclk);
      aresetn      = 1'b0;
      data_sram_en = 1'b0;
      cycle(s);
      aresetn     = 1'b1;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      chk("rstw_sb_drained", 32'(sb.size()), 32'd0);
      #1;
      chk("rstw_stall", 32'(stallreq), 32'd0);
      chk("rstw_inst_rdata", inst_sram_rdata, 32'd0);
      chk("rstw_data_rdata", data_sram_rdata, 32'd0);
      @(negedge aclk);
      spur = 1'b1;
      repeat (3) cycle(s);
      chk("rstw_late_data_rdata", data_sram_rdata, 32'd0);
      chk("rstw_late_inst_rdata", inst_sram_rdata, 32'd0);

      run_vec(vecs[0], 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
